// File: rtl/sdm_inp_buf_sync.sv
// Router input buffer: PD-deep flit FIFO, XY route decode of each head flit,
// one-hot output-port request, and drop of frames illegal for this port.
module sdm_inp_buf_sync #(
    parameter int DIR = 0,
    parameter int DW  = 32,
    parameter int AW  = 8,
    parameter int PD  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [DW-1:0]          in_dat,
    input  logic                   in_eof,
    output logic                   in_rdy,
    output logic                   out_vld,
    output logic [DW-1:0]          out_dat,
    output logic                   out_eof,
    input  logic                   out_rdy,
    input  logic [AW-1:0]          addrx,
    input  logic [AW-1:0]          addry,
    output logic [4:0]             arb_r,
    input  logic                   arb_ra,
    output logic                   rt_err,
    output logic [$clog2(PD):0]    occ
);

    localparam int PW = $clog2(PD);
    localparam int OW = PW + 1;

    // One-hot port encoding {L,E,N,W,S}
    localparam logic [4:0] P_S = 5'b00001;
    localparam logic [4:0] P_W = 5'b00010;
    localparam logic [4:0] P_N = 5'b00100;
    localparam logic [4:0] P_E = 5'b01000;
    localparam logic [4:0] P_L = 5'b10000;

    // No U-turns, and a flit that arrived travelling in Y may not turn back into X
    localparam logic [4:0] LEGAL =
        (DIR == 0) ? (P_N | P_L) :
        (DIR == 1) ? (P_E | P_N | P_S | P_L) :
        (DIR == 2) ? (P_S | P_L) :
        (DIR == 3) ? (P_W | P_N | P_S | P_L) :
                     (P_S | P_W | P_N | P_E);

    typedef struct packed {
        logic          eof;
        logic [DW-1:0] dat;
    } flit_t;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    flit_t          mem [PD];
    flit_t          head;
    logic [PW-1:0]  wr_ptr, rd_ptr;
    state_t         state, state_nx;
    logic [4:0]     dec, dec_nx;
    logic [4:0]     route;
    logic [AW-1:0]  tx, ty;
    logic           push, pop, not_empty, full;

    assign head      = mem[rd_ptr];
    assign tx        = head.dat[AW-1:0];
    assign ty        = head.dat[2*AW-1:AW];
    assign not_empty = (occ != '0);
    assign full      = (occ == OW'(PD));

    // Space is judged on the registered occupancy, so a pop frees a slot one cycle later
    assign in_rdy = ~rst & ~full;
    assign push   = in_vld & in_rdy;

    assign out_dat = head.dat;
    assign out_eof = head.eof;
    assign arb_r   = (state == REQ) ? dec : 5'b00000;
    assign rt_err  = (state == DROP);

    // X is resolved before Y
    always_comb begin
        route = P_L;
        if (tx > addrx)      route = P_E;
        else if (tx < addrx) route = P_W;
        else if (ty > addry) route = P_S;
        else if (ty < addry) route = P_N;
    end

    always_comb begin
        state_nx = state;
        dec_nx   = dec;
        pop      = 1'b0;
        out_vld  = 1'b0;
        case (state)
            IDLE: begin
                if (not_empty) begin
                    if ((route & LEGAL) != 5'b00000) begin
                        dec_nx   = route;
                        state_nx = REQ;
                    end else begin
                        state_nx = DROP;
                    end
                end
            end
            REQ: begin
                out_vld = arb_ra & not_empty;
                pop     = out_vld & out_rdy;
                if (pop && head.eof) state_nx = IDLE;
            end
            DROP: begin
                // Discard regardless of downstream readiness
                pop = not_empty;
                if (pop && head.eof) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{eof: in_eof, dat: in_dat};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            state  <= IDLE;
            dec    <= '0;
        end else begin
            state <= state_nx;
            dec   <= dec_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: doc/sdm_inp_buf_sync.md
# sdm_inp_buf_sync

Clocked, parametrised input buffer for the synchronous wormhole/SDM router ports. It queues incoming flits in a PD-deep FIFO and decodes the XY destination of each head flit against the local router address. It then requests the matching output port from the arbiter and forwards the frame once granted. Frames whose destination is illegal for this port (U-turn or XY violation) are discarded up to their tail flit and flagged on `rt_err`.

## Interface
- DIR, 0: port direction; 0 south, 1 west, 2 north, 3 east, 4 local.
- DW, 32: flit payload width; must be ≥ 2*AW.
- AW, 8: width of each coordinate (x and y).
- PD, 4: FIFO depth in flits; power of two, ≥ 2.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_vld  in  1  upstream flit valid.
- in_dat  in  DW  upstream flit payload.
- in_eof  in  1  upstream tail-flit marker.
- in_rdy  out  1  buffer can accept a flit this cycle.
- out_vld  out  1  flit valid toward crossbar.
- out_dat  out  DW  flit payload toward crossbar.
- out_eof  out  1  tail-flit marker toward crossbar.
- out_rdy  in  1  crossbar accepts flit.
- addrx, addry  in  AW each  local router coordinates; static after reset.
- arb_r  out  5  one-hot output-port request {L,E,N,W,S} (bit 0 = S).
- arb_ra  in  1  arbiter grant, level, held while arb_r is held.
- rt_err  out  1  high while a frame is being dropped.
- occ  out  $clog2(PD)+1  FIFO occupancy.

## Operation
- FIFO: circular, PD entries of {eof, dat}; write/read pointers wrap modulo PD; occ counts 0..PD.
- Push when in_vld & in_rdy; in_rdy = ~rst & (occ != PD). No push when full, even with a simultaneous pop.
- Simultaneous push and pop: occ is unchanged.
- Head-flit fields: target x = dat[AW-1:0]; target y = dat[2AW-1:AW]; unsigned compares.
- Direction decode, in priority order:
  - tx > addrx: E
  - tx < addrx: W
  - ty > addry: S
  - ty < addry: N
  - otherwise: L
- Legal destinations per port:
  - S port: {N, L}
  - N port: {S, L}
  - W port: {E, N, S, L}
  - E port: {W, N, S, L}
  - L port: {S, W, N, E}
- FSM states are IDLE, REQ and DROP.
- IDLE:
  - If the FIFO is non-empty, decode the flit at the FIFO head (always a head flit).
  - Legal direction: register the one-hot result into dec and go to REQ.
  - Illegal direction: go to DROP.
  - No pop occurs in IDLE.
- REQ:
  - arb_r = dec.
  - out_vld = arb_ra & (occ != 0); out_dat/out_eof come from the FIFO head.
  - Pop on out_vld & out_rdy.
  - When the popped flit has eof = 1, go to IDLE; arb_r drops to 0 on the next cycle.
  - arb_ra deasserting mid-frame stalls the frame and keeps the request; no error.
- DROP:
  - out_vld = 0, arb_r = 0, rt_err = 1.
  - Pop one flit per cycle when non-empty, ignoring out_rdy.
  - Go to IDLE after popping the flit with eof = 1.
- Single-flit frame: the head is also the tail; the same rules apply.
- out_dat and out_eof are don't-care when out_vld = 0.

## Timing
- Reset values: FIFO empty, occ = 0, in_rdy = 0 while rst = 1, out_vld = 0, arb_r = 0, rt_err = 0, FSM = IDLE.
- rst asserted mid-frame: the FIFO is flushed and arb_r drops on the next edge; in-flight flits are lost.
- Push at edge t makes the flit visible at the FIFO head in cycle t+1.
  - arb_r (or rt_err) is asserted from cycle t+2.
  - With arb_ra already high, the first out_vld is in cycle t+2.
- Throughput:
  - One flit per cycle once granted.
  - One idle cycle between back-to-back frames (the IDLE decode cycle).
  - Dropped flits are discarded at one per cycle.
- in_rdy reflects occ registered at the previous edge, so a pop does not free space in the same cycle.
- Outputs arb_r, rt_err and in_rdy are glitch-free (driven from registers plus simple gating); out_vld is combinational from state, occ and arb_ra.

## Test plan
- Reset, then DIR=4, addr (2,3); push a 3-flit frame with head tx=5, ty=3 -> arb_r = 5'b01000 (E) from cycle 2. Hold arb_ra=1, out_rdy=1 -> 3 flits out on consecutive cycles, arb_r = 0 the cycle after the tail.
- DIR=0, addr (2,3); head tx=4 (E illegal at S port), 4-flit frame -> rt_err high for 4 cycles, out_vld never asserted. A following legal frame with tx=2, ty=1 gets arb_r = N (5'b00100).
- Fill: out_rdy=0, push PD+2 flits -> in_rdy = 0 once occ = PD. Release out_rdy -> in_rdy returns 1 the cycle after the first pop; no flit lost or duplicated.
- Grant toggling: drop arb_ra for 3 cycles mid-frame -> out_vld = 0 during the gap, arb_r held, payload order preserved.
- Single-flit frames back-to-back at tx=2, ty=3 (L) on DIR=1 -> each yields arb_r = 5'b10000 for exactly 1 flit, with 1 idle cycle between frames.
- Assert rst for 1 cycle mid-frame with occ = 3 -> next cycle occ = 0, arb_r = 0, FSM in IDLE; the next head is decoded correctly.
